// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : parity mode encodings, parity engine states, parity-bit mapping |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef logic [2:0] par_mode_t;

  localparam par_mode_t PAR_NONE  = 3'b000;
  localparam par_mode_t PAR_ODD   = 3'b001;
  localparam par_mode_t PAR_EVEN  = 3'b010;
  localparam par_mode_t PAR_MARK  = 3'b011;
  localparam par_mode_t PAR_SPACE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CHECK = 2'd2
  } eng_state_t;

  function automatic logic par_is_reserved(input par_mode_t mode);
    return (mode > PAR_SPACE);
  endfunction

  // acc is the XOR of all data bits; reserved codes map to NONE's value
  function automatic logic par_bit_for_mode(input par_mode_t mode, input logic acc);
    logic pb;
    case (mode)
      PAR_ODD:  pb = ~acc;
      PAR_EVEN: pb = acc;
      PAR_MARK: pb = 1'b1;
      default:  pb = 1'b0;
    endcase
    return pb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_parity_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_parity_engine_if : bit-strobe and status bundle of the parity engine  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface uart_parity_engine_if;
  import uart_pkg::*;

  par_mode_t parity_type;
  logic      start;
  logic      bit_valid;
  logic      bit_in;
  logic      busy;
  logic      parity_bit;
  logic      parity_valid;
  logic      check_done;
  logic      parity_err;
  logic      cfg_err;

  modport master (
    output parity_type, start, bit_valid, bit_in,
    input  busy, parity_bit, parity_valid, check_done, parity_err, cfg_err
  );

  modport slave (
    input  parity_type, start, bit_valid, bit_in,
    output busy, parity_bit, parity_valid, check_done, parity_err, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_parity_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_parity_engine : serial parity generator/checker for UART Tx and Rx    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_parity_engine
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_parity_engine_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  eng_state_t        state_q, state_d;
  logic              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  par_mode_t         mode_q, mode_d;
  logic              parity_bit_q, parity_bit_d;
  logic              parity_valid_q, parity_valid_d;
  logic              check_done_q, check_done_d;
  logic              parity_err_q, parity_err_d;
  logic              cfg_err_q, cfg_err_d;
  logic              acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      acc_q          <= 1'b0;
      cnt_q          <= '0;
      mode_q         <= PAR_NONE;
      parity_bit_q   <= 1'b1;
      parity_valid_q <= 1'b0;
      check_done_q   <= 1'b0;
      parity_err_q   <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      parity_bit_q   <= parity_bit_d;
      parity_valid_q <= parity_valid_d;
      check_done_q   <= check_done_d;
      parity_err_q   <= parity_err_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    mode_d         = mode_q;
    parity_bit_d   = parity_bit_q;
    parity_valid_d = parity_valid_q;
    check_done_d   = 1'b0;
    parity_err_d   = parity_err_q;
    cfg_err_d      = cfg_err_q;
    acc_next       = acc_q ^ bus.bit_in;

    // start overrides any bit strobe in the same cycle
    if (bus.start) begin
      state_d        = ST_ACCUM;
      acc_d          = 1'b0;
      cnt_d          = '0;
      mode_d         = par_is_reserved(bus.parity_type) ? PAR_NONE : bus.parity_type;
      parity_valid_d = 1'b0;
      parity_err_d   = 1'b0;
      cfg_err_d      = par_is_reserved(bus.parity_type);
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (bus.bit_valid) begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              parity_valid_d = 1'b1;
              parity_bit_d   = par_bit_for_mode(mode_q, acc_next);
              if (mode_q == PAR_NONE) begin
                state_d      = ST_IDLE;
                check_done_d = 1'b1;
                parity_err_d = 1'b0;
              end else begin
                state_d = ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          if (bus.bit_valid) begin
            parity_err_d = (bus.bit_in != parity_bit_q);
            check_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.parity_bit   = parity_bit_q;
  assign bus.parity_valid = parity_valid_q;
  assign bus.check_done   = check_done_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.cfg_err      = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_parity_engine.sv
`default_nettype none
// Bench for uart_parity_engine: directed scenarios on 8- and 7-bit instances,
// then random frames checked against a frame-level parity model.
module tb_uart_parity_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel7 = 1'b0;
  logic [2:0] ptype = 3'b000;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  uart_parity_engine_if if8 ();
  uart_parity_engine_if if7 ();

  assign if8.parity_type = ptype;
  assign if7.parity_type = ptype;
  assign if8.bit_in      = bit_in;
  assign if7.bit_in      = bit_in;
  assign if8.start       = start & ~sel7;
  assign if7.start       = start & sel7;
  assign if8.bit_valid   = bit_valid & ~sel7;
  assign if7.bit_valid   = bit_valid & sel7;

  uart_parity_engine #(.DATA_WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
  uart_parity_engine #(.DATA_WIDTH(7)) dut7 (.clk(clk), .reset(reset), .bus(if7.slave));

  logic o_busy, o_pb, o_pv, o_cd, o_pe, o_ce;
  assign o_busy = sel7 ? if7.busy         : if8.busy;
  assign o_pb   = sel7 ? if7.parity_bit   : if8.parity_bit;
  assign o_pv   = sel7 ? if7.parity_valid : if8.parity_valid;
  assign o_cd   = sel7 ? if7.check_done   : if8.check_done;
  assign o_pe   = sel7 ? if7.parity_err   : if8.parity_err;
  assign o_ce   = sel7 ? if7.cfg_err      : if8.cfg_err;

  // Reference: parity from the count of ones in the frame's data bits
  function automatic logic model_pb(input logic [2:0] mode, input logic [8:0] data, input int w);
    int ones = 0;
    for (int i = 0; i < w; i++) ones += int'(data[i]);
    case (mode)
      3'd1: return (ones % 2 == 0);
      3'd2: return (ones % 2 == 1);
      3'd3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_checked(input logic [2:0] mode);
    return (mode >= 3'd1 && mode <= 3'd4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] mode);
    ptype = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    ptype = 3'($urandom_range(0, 7));
  endtask

  task automatic send_bits(input logic [8:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in    = data[i];
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel7 = s[0];
      #1;
      vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy w%0d: got %b want 0", 8 - s, o_busy); end
      vectors++; if (o_pb !== 1'b1) begin miscompares++; $display("FAIL reset_pb w%0d: got %b want 1", 8 - s, o_pb); end
      vectors++; if (o_pv !== 1'b0) begin miscompares++; $display("FAIL reset_pv w%0d: got %b want 0", 8 - s, o_pv); end
      vectors++; if (o_cd !== 1'b0) begin miscompares++; $display("FAIL reset_cd w%0d: got %b want 0", 8 - s, o_cd); end
      vectors++; if (o_pe !== 1'b0) begin miscompares++; $display("FAIL reset_pe w%0d: got %b want 0", 8 - s, o_pe); end
      vectors++; if (o_ce !== 1'b0) begin miscompares++; $display("FAIL reset_ce w%0d: got %b want 0", 8 - s, o_ce); end
    end
    sel7 = 1'b0;
  endtask

  task automatic test_even();
    do_start(3'd2);
    send_bits(9'h0A5, 7);
    vectors++; if (o_pv !== 1'b0) begin miscompares++; $display("FAIL even_pv_early: got %b want 0", o_pv); end
    send_bits(9'h0A5 >> 7, 1);
    vectors++; if (o_pv !== 1'b1) begin miscompares++; $display("FAIL even_pv: got %b want 1", o_pv); end
    vectors++; if (o_pb !== 1'b0) begin miscompares++; $display("FAIL even_pb: got %b want 0", o_pb); end
    vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL even_busy_check: got %b want 1", o_busy); end
    send_bits(9'h000, 1);
    vectors++; if (o_cd !== 1'b1) begin miscompares++; $display("FAIL even_cd: got %b want 1", o_cd); end
    vectors++; if (o_pe !== 1'b0) begin miscompares++; $display("FAIL even_pe: got %b want 0", o_pe); end
    tick();
    vectors++; if (o_cd !== 1'b0) begin miscompares++; $display("FAIL even_cd_pulse: got %b want 0", o_cd); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL even_busy_idle: got %b want 0", o_busy); end
  endtask

  task automatic test_odd_err();
    do_start(3'd1);
    send_bits(9'h007, 8);
    vectors++; if (o_pb !== 1'b0) begin miscompares++; $display("FAIL odd_pb: got %b want 0", o_pb); end
    send_bits(9'h001, 1);
    vectors++; if (o_cd !== 1'b1) begin miscompares++; $display("FAIL odd_cd: got %b want 1", o_cd); end
    vectors++; if (o_pe !== 1'b1) begin miscompares++; $display("FAIL odd_pe: got %b want 1", o_pe); end
    repeat (20) tick();
    vectors++; if (o_pe !== 1'b1) begin miscompares++; $display("FAIL odd_pe_held: got %b want 1", o_pe); end
    vectors++; if (o_pv !== 1'b1 || o_pb !== 1'b0) begin miscompares++; $display("FAIL odd_pv_pb_held: got %b/%b want 1/0", o_pv, o_pb); end
    do_start(3'd2);
    vectors++; if (o_pe !== 1'b0) begin miscompares++; $display("FAIL odd_pe_clear: got %b want 0", o_pe); end
    vectors++; if (o_pv !== 1'b0) begin miscompares++; $display("FAIL start_pv_clear: got %b want 0", o_pv); end
  endtask

  task automatic test_none();
    do_start(3'd0);
    send_bits(9'h0FF, 8);
    vectors++; if (o_cd !== 1'b1) begin miscompares++; $display("FAIL none_cd: got %b want 1", o_cd); end
    vectors++; if (o_pb !== 1'b0 || o_pv !== 1'b1) begin miscompares++; $display("FAIL none_pb_pv: got %b/%b want 0/1", o_pb, o_pv); end
    vectors++; if (o_pe !== 1'b0) begin miscompares++; $display("FAIL none_pe: got %b want 0", o_pe); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL none_busy: got %b want 0", o_busy); end
    send_bits(9'h1FF, 3);
    vectors++; if (o_cd !== 1'b0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL idle_ignores_bits: cd/busy got %b/%b want 0/0", o_cd, o_busy); end
  endtask

  task automatic test_width7();
    sel7 = 1'b1;
    do_start(3'd3);
    send_bits(9'h000, 7);
    vectors++; if (o_pv !== 1'b1 || o_pb !== 1'b1) begin miscompares++; $display("FAIL w7_mark_pv_pb: got %b/%b want 1/1", o_pv, o_pb); end
    send_bits(9'h000, 1);
    vectors++; if (o_cd !== 1'b1 || o_pe !== 1'b1) begin miscompares++; $display("FAIL w7_mark_cd_pe: got %b/%b want 1/1", o_cd, o_pe); end
    do_start(3'd4);
    send_bits(9'h07F, 7);
    vectors++; if (o_pv !== 1'b1 || o_pb !== 1'b0) begin miscompares++; $display("FAIL w7_space_pv_pb: got %b/%b want 1/0", o_pv, o_pb); end
    send_bits(9'h000, 1);
    vectors++; if (o_cd !== 1'b1 || o_pe !== 1'b0) begin miscompares++; $display("FAIL w7_space_cd_pe: got %b/%b want 1/0", o_cd, o_pe); end
    sel7 = 1'b0;
  endtask

  task automatic test_abort();
    do_start(3'd2);
    send_bits(9'h001, 4);
    do_start(3'd2);
    send_bits(9'h003, 8);
    vectors++; if (o_pv !== 1'b1 || o_pb !== 1'b0) begin miscompares++; $display("FAIL abort_restart_pb: pv/pb got %b/%b want 1/0", o_pv, o_pb); end
    // start with a simultaneous strobe: that bit must not count
    ptype = 3'd2; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    send_bits(9'h000, 7);
    vectors++; if (o_pv !== 1'b0) begin miscompares++; $display("FAIL start_drops_bit_pv: got %b want 0", o_pv); end
    send_bits(9'h000, 1);
    vectors++; if (o_pv !== 1'b1 || o_pb !== 1'b0) begin miscompares++; $display("FAIL start_drops_bit_pb: pv/pb got %b/%b want 1/0", o_pv, o_pb); end
    do_start(3'd1);
    send_bits(9'h0FF, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (o_busy !== 1'b0 || o_pb !== 1'b1) begin miscompares++; $display("FAIL midreset_busy_pb: got %b/%b want 0/1", o_busy, o_pb); end
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
      vectors++; if (o_cd !== 1'b0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL midreset_no_cd: cd/busy got %b/%b want 0/0", o_cd, o_busy); end
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_cfg_err();
    do_start(3'b110);
    vectors++; if (o_ce !== 1'b1) begin miscompares++; $display("FAIL cfg_err_set: got %b want 1", o_ce); end
    send_bits(9'h055, 8);
    vectors++; if (o_cd !== 1'b1 || o_pe !== 1'b0 || o_pb !== 1'b0) begin miscompares++; $display("FAIL cfg_err_as_none: cd/pe/pb got %b/%b/%b want 1/0/0", o_cd, o_pe, o_pb); end
    vectors++; if (o_ce !== 1'b1) begin miscompares++; $display("FAIL cfg_err_held: got %b want 1", o_ce); end
    do_start(3'd2);
    vectors++; if (o_ce !== 1'b0) begin miscompares++; $display("FAIL cfg_err_clear: got %b want 0", o_ce); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      logic [2:0] mode;
      logic [8:0] data;
      logic       epb, rb;
      int         w;
      bit         chk;
      sel7 = 1'($urandom_range(0, 1));
      w    = sel7 ? 7 : 8;
      mode = 3'($urandom_range(0, 7));
      data = 9'($urandom);
      epb  = model_pb(mode, data, w);
      chk  = model_checked(mode);
      do_start(mode);
      vectors++; if (o_ce !== (mode > 3'd4) || o_busy !== 1'b1) begin miscompares++; $display("FAIL rnd_start f%0d: ce/busy got %b/%b want %b/1", f, o_ce, o_busy, mode > 3'd4); end
      for (int i = 0; i < w; i++) begin
        while ($urandom_range(0, 3) == 0) tick();
        send_bits(data >> i, 1);
      end
      vectors++; if (o_pv !== 1'b1 || o_pb !== epb) begin miscompares++; $display("FAIL rnd_pb f%0d mode%0d w%0d data %h: pv/pb got %b/%b want 1/%b", f, mode, w, data, o_pv, o_pb, epb); end
      vectors++; if (o_cd !== !chk || o_busy !== chk) begin miscompares++; $display("FAIL rnd_end f%0d mode%0d: cd/busy got %b/%b want %b/%b", f, mode, o_cd, o_busy, !chk, chk); end
      if (chk) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat (3) tick();
          vectors++; if (o_busy !== 1'b1 || o_cd !== 1'b0) begin miscompares++; $display("FAIL rnd_tx_hold f%0d: busy/cd got %b/%b want 1/0", f, o_busy, o_cd); end
        end else begin
          rb = 1'($urandom_range(0, 1));
          while ($urandom_range(0, 2) == 0) tick();
          send_bits({8'h00, rb}, 1);
          vectors++; if (o_cd !== 1'b1 || o_pe !== (rb != epb) || o_busy !== 1'b0) begin miscompares++; $display("FAIL rnd_check f%0d: cd/pe/busy got %b/%b/%b want 1/%b/0", f, o_cd, o_pe, o_busy, rb != epb); end
        end
      end
    end
    sel7 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd_err();
    test_none();
    test_width7();
    test_abort();
    test_cfg_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_parity_engine.md
Name: uart_parity_engine

Overview:
Serial parity generator/checker for the UART Tx and Rx datapaths. It replaces the fixed 8-bit combinational parity calculator. The block accumulates parity one bit at a time as data bits are shifted, with a parametrised data width and five parity modes. On the Rx side it also accepts the received parity bit and flags a mismatch. One instance sits beside each Tx and Rx shift register and is driven by that unit's bit strobe.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CNT_W, $clog2(DATA_WIDTH+1), width of the bit counter; derived, not to be overridden.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
parity_type  input  3  parity mode, sampled only on start: 000 NONE, 001 ODD, 010 EVEN, 011 MARK, 100 SPACE, 101-111 reserved.
start  input  1  one-cycle pulse; begins a new frame.
bit_valid  input  1  qualifies bit_in; one bit accepted per asserted cycle.
bit_in  input  1  data bit (LSB first), or the received parity bit while in CHECK.
busy  output  1  high in ACCUM and CHECK.
parity_bit  output  1  computed parity bit for Tx.
parity_valid  output  1  parity_bit valid for the current frame.
check_done  output  1  one-cycle pulse when the frame check completes.
parity_err  output  1  received parity mismatched; held until the next start or reset.
cfg_err  output  1  reserved parity_type latched at start; held until the next start or reset.

Behaviour:
- Reset (reset=1 at a clock edge, in any state):
  - state=IDLE, acc=0, cnt=0, mode=NONE.
  - busy=0, parity_valid=0, check_done=0, parity_err=0, cfg_err=0.
  - parity_bit=1 (idle-line level).
  - Reset wins over every other input; reset mid-frame abandons the frame with no check_done.
- States: IDLE, ACCUM, CHECK.
- start (any state):
  - acc=0, cnt=0, mode latched from parity_type.
  - parity_valid=0, parity_err=0, check_done=0.
  - cfg_err=1 if the code is reserved (the mode then behaves as NONE).
  - Next state ACCUM.
  - start mid-frame aborts the current frame silently. If bit_valid is high in the same cycle, start wins and that bit is discarded.
- IDLE: bit_valid is ignored.
- ACCUM, on bit_valid: acc <= acc ^ bit_in; cnt <= cnt+1.
- Last data bit (bit_valid while cnt==DATA_WIDTH-1):
  - Next cycle: parity_valid=1 and parity_bit is final.
  - Latency is 1 cycle after the last bit is accepted.
  - parity_bit by mode: ODD=~acc, EVEN=acc, MARK=1, SPACE=0, NONE=0.
  - Mode NONE (or reserved): go to IDLE. check_done pulses in that same cycle with parity_err=0.
  - All other modes: go to CHECK.
- CHECK, on bit_valid:
  - parity_err <= (bit_in != parity_bit).
  - check_done pulses the next cycle (1-cycle latency); state returns to IDLE.
  - Tx instances simply never send a check bit and leave the engine in CHECK until the next start; busy stays high in that case.
- parity_valid and parity_bit hold their values in IDLE until the next start or reset.
- parity_type changes outside a start cycle have no effect.
- cnt never exceeds DATA_WIDTH; no wrap-around is possible, because ACCUM is exited on the last bit.
- Outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package uart_pkg holds:
  - the parity_type encodings (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE), shared with the Tx/Rx controllers;
  - the state encoding for this engine.
- The mode-to-parity_bit mapping is a function in uart_pkg, so the Rx controller can reuse it.
- No sub-module; a single module is sufficient.

Test Plan:
1. DATA_WIDTH=8, EVEN, bits of 0xA5 LSB-first, then received parity 0 -> parity_bit=0 and parity_valid=1 one cycle after the 8th bit; then check_done=1 with parity_err=0.
2. ODD, data 0x07, received parity 1 -> parity_bit=0, parity_err=1, check_done pulse; parity_err still 1 twenty cycles later; cleared by the next start.
3. NONE, data 0xFF -> check_done pulses one cycle after the 8th bit, parity_bit=0, parity_err=0, state IDLE; a subsequent bit_valid is ignored (cnt unchanged).
4. DATA_WIDTH=7, MARK, data 0x00, received parity 0 -> parity_bit=1, parity_err=1. SPACE, data 0x7F, received parity 0 -> parity_err=0.
5. Abort cases:
   - start after 4 bits of EVEN 0x01, then a full frame 0x03 -> parity_bit=0 (the first frame is discarded).
   - start and bit_valid asserted together -> that bit is dropped.
   - reset after 5 bits -> busy=0, parity_bit=1, and no check_done pulse.
6. parity_type=110 at start, data 0x55 -> cfg_err=1, behaves as NONE (check_done after the 8th bit, parity_err=0); cfg_err clears on the next valid start.
